// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 encodings for the execute stage: instruction codes, condition
// function codes, the "no register" id, ALU control encodings, the layout of
// the E->M pipeline register and the branch/cmov condition evaluator.
// No ports (package).
// -----------------------------------------------------------------------------
package y86_pkg;

   // instruction codes (icode)
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;   // also CMOVXX
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // condition function codes (ifun of JXX / CMOVXX)
   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [3:0] RNONE = 4'hF;

   // ALU control
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;   // A - B
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_XOR = 2'b11;

   // E->M pipeline register contents
   typedef struct packed {
      logic        valid;
      logic [3:0]  icode;
      logic        cnd;
      logic [63:0] valE;
      logic [63:0] valA;
      logic [3:0]  dstE;
      logic [3:0]  dstM;
   } m_reg_t;

   // NOP image loaded on bubble, on an empty E slot and under reset
   localparam m_reg_t M_BUBBLE = '{valid: 1'b0, icode: I_NOP, cnd: 1'b0,
                                   valE: 64'd0, valA: 64'd0,
                                   dstE: RNONE, dstM: RNONE};

   // Evaluate a condition function code against the flags.
   function automatic logic cond_eval(input logic [3:0] ifun, input logic zf,
                                      input logic sf, input logic of);
      logic lt;
      logic res;
      lt  = sf ^ of;
      res = 1'b0;
      case (ifun)
         C_YES:   res = 1'b1;
         C_LE:    res = lt | zf;
         C_L:     res = lt;
         C_E:     res = zf;
         C_NE:    res = ~zf;
         C_GE:    res = ~lt;
         C_G:     res = ~lt & ~zf;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// -----------------------------------------------------------------------------
// alu
// 64-bit two's-complement ALU. Carry-out is discarded; o_of reports signed
// overflow for add/sub and is 0 for the logic operations.
// Ports:
//   i_a, i_b  in  64  operands (subtract computes i_a - i_b)
//   i_ctl     in  2   ALU_ADD / ALU_SUB / ALU_AND / ALU_XOR
//   o_res     out 64  result
//   o_of      out 1   signed overflow
// -----------------------------------------------------------------------------
module alu
   import y86_pkg::*;
(
   input  logic [63:0] i_a,
   input  logic [63:0] i_b,
   input  logic [1:0]  i_ctl,
   output logic [63:0] o_res,
   output logic        o_of
);

   logic [63:0] w_sum;
   logic [63:0] w_diff;

   assign w_sum  = i_a + i_b;
   assign w_diff = i_a - i_b;

   // Operation select; overflow = operands of compatible sign producing a result of the other sign
   always_comb begin
      o_res = 64'd0;
      o_of  = 1'b0;
      case (i_ctl)
         ALU_ADD: begin
            o_res = w_sum;
            o_of  = (i_a[63] == i_b[63]) && (w_sum[63] != i_a[63]);
         end
         ALU_SUB: begin
            o_res = w_diff;
            o_of  = (i_a[63] != i_b[63]) && (w_diff[63] != i_a[63]);
         end
         ALU_AND: o_res = i_a & i_b;
         ALU_XOR: o_res = i_a ^ i_b;
         default: begin
            o_res = 64'd0;
            o_of  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
// Y86-64 execute stage: operand selection, ALU, condition evaluation, the
// architectural condition codes and the E->M pipeline register.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   e_valid/e_icode/e_ifun     E-stage instruction
//   e_valA/e_valB/e_valC       E-stage operands (64)
//   e_dstE/e_dstM              destination register ids
//   m_stall/m_bubble/m_exc     M-register hold, NOP injection, CC-update block
//   M_*                        registered M-stage outputs
//   cc_zf/cc_sf/cc_of          architectural flags
//   e_cnd/e_valE/e_dstE_fwd    combinational results for branch/forwarding
// -----------------------------------------------------------------------------
module execute_stage
   import y86_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        e_valid,
   input  logic [3:0]  e_icode,
   input  logic [3:0]  e_ifun,
   input  logic [63:0] e_valA,
   input  logic [63:0] e_valB,
   input  logic [63:0] e_valC,
   input  logic [3:0]  e_dstE,
   input  logic [3:0]  e_dstM,
   input  logic        m_stall,
   input  logic        m_bubble,
   input  logic        m_exc,
   output logic        M_valid,
   output logic [3:0]  M_icode,
   output logic        M_cnd,
   output logic [63:0] M_valE,
   output logic [63:0] M_valA,
   output logic [3:0]  M_dstE,
   output logic [3:0]  M_dstM,
   output logic        cc_zf,
   output logic        cc_sf,
   output logic        cc_of,
   output logic        e_cnd,
   output logic [63:0] e_valE,
   output logic [3:0]  e_dstE_fwd
);

   logic [63:0] w_alu_a;
   logic [63:0] w_alu_b;
   logic [1:0]  w_alu_ctl;
   logic [63:0] w_alu_res;
   logic        w_alu_of;
   logic        w_cnd;
   logic        w_set_cc;
   logic [3:0]  w_dste_fwd;
   m_reg_t      w_m_load;
   m_reg_t      r_m;
   logic        r_zf;
   logic        r_sf;
   logic        r_of;

   // Operand mux: every non-OPq instruction uses the ALU as a plain adder
   always_comb begin
      w_alu_a   = 64'd0;
      w_alu_b   = 64'd0;
      w_alu_ctl = ALU_ADD;
      case (e_icode)
         I_OPQ: begin
            w_alu_a   = e_valB;
            w_alu_b   = e_valA;
            w_alu_ctl = e_ifun[1:0];
         end
         I_RRMOVQ: w_alu_a = e_valA;
         I_IRMOVQ: w_alu_a = e_valC;
         I_RMMOVQ, I_MRMOVQ: begin
            w_alu_a = e_valB;
            w_alu_b = e_valC;
         end
         I_CALL, I_PUSHQ: begin
            w_alu_a = e_valB;
            w_alu_b = 64'hFFFF_FFFF_FFFF_FFF8;   // -8
         end
         I_RET, I_POPQ: begin
            w_alu_a = e_valB;
            w_alu_b = 64'd8;
         end
         default: begin
            w_alu_a   = 64'd0;
            w_alu_b   = 64'd0;
            w_alu_ctl = ALU_ADD;
         end
      endcase
   end

   alu u_alu (
      .i_a   (w_alu_a),
      .i_b   (w_alu_b),
      .i_ctl (w_alu_ctl),
      .o_res (w_alu_res),
      .o_of  (w_alu_of)
   );

   // Condition uses the flags as they stand before this instruction's update
   assign w_cnd    = cond_eval(e_ifun, r_zf, r_sf, r_of);
   assign w_set_cc = e_valid && (e_icode == I_OPQ) && !m_exc && !m_stall;

   // A not-taken conditional move must not write its destination
   always_comb begin
      if ((e_icode == I_RRMOVQ) && !w_cnd) begin
         w_dste_fwd = RNONE;
      end else begin
         w_dste_fwd = e_dstE;
      end
   end

   // Image of the M register for a normal (non-stall, non-bubble) advance
   always_comb begin
      w_m_load.valid = e_valid;
      w_m_load.icode = e_icode;
      w_m_load.cnd   = w_cnd;
      w_m_load.valE  = w_alu_res;
      w_m_load.valA  = e_valA;
      w_m_load.dstE  = w_dste_fwd;
      w_m_load.dstM  = e_dstM;
   end

   // Condition-code register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_zf <= 1'b1;
         r_sf <= 1'b0;
         r_of <= 1'b0;
      end else if (w_set_cc) begin
         r_zf <= (w_alu_res == 64'd0);
         r_sf <= w_alu_res[63];
         r_of <= w_alu_of;
      end
   end

   // E->M register: stall beats bubble; an empty E slot also advances as a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m <= M_BUBBLE;
      end else if (m_stall) begin
         r_m <= r_m;
      end else if (m_bubble || !e_valid) begin
         r_m <= M_BUBBLE;
      end else begin
         r_m <= w_m_load;
      end
   end

   assign M_valid    = r_m.valid;
   assign M_icode    = r_m.icode;
   assign M_cnd      = r_m.cnd;
   assign M_valE     = r_m.valE;
   assign M_valA     = r_m.valA;
   assign M_dstE     = r_m.dstE;
   assign M_dstM     = r_m.dstM;
   assign cc_zf      = r_zf;
   assign cc_sf      = r_sf;
   assign cc_of      = r_of;
   assign e_cnd      = w_cnd;
   assign e_valE     = w_alu_res;
   assign e_dstE_fwd = w_dste_fwd;

endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
// Directed vector table, hand-written stall/bubble/reset sequences and a
// randomized run against an arithmetic reference model of the execute stage.
// -----------------------------------------------------------------------------
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        e_valid;
   logic [3:0]  e_icode, e_ifun, e_dstE, e_dstM;
   logic [63:0] e_valA, e_valB, e_valC;
   logic        m_stall, m_bubble, m_exc;
   logic        M_valid, M_cnd, cc_zf, cc_sf, cc_of, e_cnd;
   logic [3:0]  M_icode, M_dstE, M_dstM, e_dstE_fwd;
   logic [63:0] M_valE, M_valA, e_valE;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode),
      .e_ifun(e_ifun), .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC),
      .e_dstE(e_dstE), .e_dstM(e_dstM), .m_stall(m_stall), .m_bubble(m_bubble),
      .m_exc(m_exc), .M_valid(M_valid), .M_icode(M_icode), .M_cnd(M_cnd),
      .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
      .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .e_cnd(e_cnd),
      .e_valE(e_valE), .e_dstE_fwd(e_dstE_fwd)
   );

   typedef struct {
      logic [3:0]  icode, ifun;
      logic [63:0] a, b, c;
      logic [3:0]  dste, dstm;
      logic        valid, bubble, exc;
      logic        x_cnd;
      logic [63:0] x_vale;
      logic [3:0]  x_fwd;
      logic [2:0]  x_flags;   // {zf, sf, of} after the edge
   } vec_t;

   vec_t vt[16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                        input logic [3:0] dm, input logic v, input logic st,
                        input logic bu, input logic ex);
      e_icode = ic; e_ifun = fn; e_valA = a; e_valB = b; e_valC = c;
      e_dstE = de; e_dstM = dm; e_valid = v; m_stall = st; m_bubble = bu; m_exc = ex;
   endtask

   // reference: returns {overflow, valE} from the instruction's meaning
   function automatic logic [64:0] ref_exe(input logic [3:0] ic, input logic [3:0] fn,
                                           input logic [63:0] a, input logic [63:0] b,
                                           input logic [63:0] c);
      logic [64:0] w;
      logic [63:0] r;
      logic        o;
      r = 64'd0;
      o = 1'b0;
      w = 65'd0;
      case (ic)
         4'h6: begin
            case (fn[1:0])
               2'd0: begin w = {b[63], b} + {a[63], a}; r = w[63:0]; o = w[64] ^ w[63]; end
               2'd1: begin w = {b[63], b} - {a[63], a}; r = w[63:0]; o = w[64] ^ w[63]; end
               2'd2: r = a & b;
               default: r = a ^ b;
            endcase
         end
         4'h2: r = a;
         4'h3: r = c;
         4'h4, 4'h5: r = b + c;
         4'h8, 4'hA: r = b - 64'd8;
         4'h9, 4'hB: r = b + 64'd8;
         default: r = 64'd0;
      endcase
      return {o, r};
   endfunction

   function automatic logic ref_cnd(input logic [3:0] fn, input logic z, input logic s,
                                    input logic o);
      logic lt;
      lt = (s != o);
      case (fn)
         4'h0: return 1'b1;
         4'h1: return lt || z;
         4'h2: return lt;
         4'h3: return z;
         4'h4: return !z;
         4'h5: return !lt;
         4'h6: return !lt && !z;
         default: return 1'b0;
      endcase
   endfunction

   logic        bub;
   logic        mv, mc, mz, ms, mo;
   logic [3:0]  mic, mde, mdm;
   logic [63:0] mve, mva;
   logic [64:0] rx;
   logic        xc;
   logic [3:0]  xf;

   initial begin
      //        icode ifun a                      b                      c                      dstE  dstM  v  bu ex cnd vale                   fwd   flags
      vt[0]  = '{4'h6, 4'h1, 64'd5,               64'd5,                 64'd0,                 4'h2, 4'hF, 1, 0, 0, 1, 64'd0,                 4'h2, 3'b100};
      vt[1]  = '{4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0,          4'h4, 4'hF, 1, 0, 0, 1, 64'h8000_0000_0000_0000, 4'h4, 3'b011};
      vt[2]  = '{4'h6, 4'h2, 64'hFF,              64'h0F,                64'd0,                 4'h5, 4'hF, 1, 0, 0, 0, 64'h0F,                4'h5, 3'b000};
      vt[3]  = '{4'h2, 4'h2, 64'h1234,            64'h999,               64'd0,                 4'h3, 4'hF, 1, 0, 0, 0, 64'h1234,              4'hF, 3'b000};
      vt[4]  = '{4'h6, 4'h1, 64'd1,               64'd0,                 64'd0,                 4'h6, 4'hF, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'h6, 3'b010};
      vt[5]  = '{4'h2, 4'h2, 64'h55,              64'd0,                 64'd0,                 4'h3, 4'hF, 1, 0, 0, 1, 64'h55,                4'h3, 3'b010};
      vt[6]  = '{4'hA, 4'h0, 64'h7,               64'h100,               64'd0,                 4'h4, 4'hF, 1, 0, 0, 1, 64'hF8,                4'h4, 3'b010};
      vt[7]  = '{4'hB, 4'h0, 64'h7,               64'h100,               64'd0,                 4'h4, 4'h1, 1, 0, 0, 1, 64'h108,               4'h4, 3'b010};
      vt[8]  = '{4'h6, 4'h3, 64'h77,              64'h77,                64'd0,                 4'h7, 4'hF, 1, 0, 1, 0, 64'd0,                 4'h7, 3'b010};
      vt[9]  = '{4'h3, 4'h0, 64'd0,               64'd0,                 64'hDEAD,              4'h8, 4'hF, 1, 0, 0, 1, 64'hDEAD,              4'h8, 3'b010};
      vt[10] = '{4'h4, 4'h0, 64'h33,              64'h10,                64'h8,                 4'hF, 4'hF, 1, 0, 0, 1, 64'h18,                4'hF, 3'b010};
      vt[11] = '{4'h6, 4'h0, 64'd1,               64'd2,                 64'd0,                 4'h9, 4'hF, 0, 0, 0, 1, 64'd3,                 4'h9, 3'b010};
      vt[12] = '{4'h6, 4'h0, 64'd1,               64'd2,                 64'd0,                 4'h9, 4'hF, 1, 1, 0, 1, 64'd3,                 4'h9, 3'b000};
      vt[13] = '{4'h5, 4'h0, 64'd0,               64'h20,                64'hFFFF_FFFF_FFFF_FFF0, 4'hF, 4'h2, 1, 0, 0, 1, 64'h10,              4'hF, 3'b000};
      vt[14] = '{4'h6, 4'h1, 64'd1,               64'h8000_0000_0000_0000, 64'd0,               4'h1, 4'hF, 1, 0, 0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 4'h1, 3'b001};
      vt[15] = '{4'h2, 4'h0, 64'hABC,             64'd0,                 64'd0,                 4'h3, 4'hF, 1, 0, 0, 1, 64'hABC,               4'h3, 3'b001};

      // reset state
      rst_n = 1'b0;
      drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_M_valid", 64'(M_valid), 64'd0);
      chk("rst_M_icode", 64'(M_icode), 64'd1);
      chk("rst_M_dstE", 64'(M_dstE), 64'hF);
      chk("rst_M_dstM", 64'(M_dstM), 64'hF);
      chk("rst_M_valE", M_valE, 64'd0);
      chk("rst_flags", 64'({cc_zf, cc_sf, cc_of}), 64'b100);
      rst_n = 1'b1;

      // directed vector table
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vt[i].icode, vt[i].ifun, vt[i].a, vt[i].b, vt[i].c, vt[i].dste, vt[i].dstm,
               vt[i].valid, 1'b0, vt[i].bubble, vt[i].exc);
         #1;
         chk($sformatf("v%0d_e_cnd", i), 64'(e_cnd), 64'(vt[i].x_cnd));
         chk($sformatf("v%0d_e_valE", i), e_valE, vt[i].x_vale);
         chk($sformatf("v%0d_e_dstE_fwd", i), 64'(e_dstE_fwd), 64'(vt[i].x_fwd));
         @(posedge clk);
         #1;
         bub = vt[i].bubble || !vt[i].valid;
         chk($sformatf("v%0d_M_valid", i), 64'(M_valid), bub ? 64'd0 : 64'd1);
         chk($sformatf("v%0d_M_icode", i), 64'(M_icode), bub ? 64'd1 : 64'(vt[i].icode));
         chk($sformatf("v%0d_M_cnd", i), 64'(M_cnd), bub ? 64'd0 : 64'(vt[i].x_cnd));
         chk($sformatf("v%0d_M_valE", i), M_valE, bub ? 64'd0 : vt[i].x_vale);
         chk($sformatf("v%0d_M_valA", i), M_valA, bub ? 64'd0 : vt[i].a);
         chk($sformatf("v%0d_M_dstE", i), 64'(M_dstE), bub ? 64'hF : 64'(vt[i].x_fwd));
         chk($sformatf("v%0d_M_dstM", i), 64'(M_dstM), bub ? 64'hF : 64'(vt[i].dstm));
         chk($sformatf("v%0d_flags", i), 64'({cc_zf, cc_sf, cc_of}), 64'(vt[i].x_flags));
      end

      // stall + bubble together holds everything, then bubble alone injects a NOP
      @(negedge clk);
      drive(4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 4'hA, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("sb_load_valE", M_valE, 64'd5);
      chk("sb_load_flags", 64'({cc_zf, cc_sf, cc_of}), 64'b000);
      @(negedge clk);
      drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'hB, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("sb_hold_valid", 64'(M_valid), 64'd1);
      chk("sb_hold_icode", 64'(M_icode), 64'h6);
      chk("sb_hold_valE", M_valE, 64'd5);
      chk("sb_hold_valA", M_valA, 64'd2);
      chk("sb_hold_dstE", 64'(M_dstE), 64'hA);
      chk("sb_hold_flags", 64'({cc_zf, cc_sf, cc_of}), 64'b000);
      @(negedge clk);
      drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
      @(posedge clk); #1;
      chk("bub_icode", 64'(M_icode), 64'd1);
      chk("bub_valid", 64'(M_valid), 64'd0);
      chk("bub_valE", M_valE, 64'd0);
      chk("bub_flags", 64'({cc_zf, cc_sf, cc_of}), 64'b000);

      // asynchronous reset pulsed between edges
      @(negedge clk);
      drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("ar_pre_valid", 64'(M_valid), 64'd1);
      chk("ar_pre_sf", 64'(cc_sf), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_now_valid", 64'(M_valid), 64'd0);
      chk("ar_now_icode", 64'(M_icode), 64'd1);
      chk("ar_now_valE", M_valE, 64'd0);
      chk("ar_now_flags", 64'({cc_zf, cc_sf, cc_of}), 64'b100);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'h3, 4'h0, 64'd4, 64'd0, 64'h77, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("ar_post_valE", M_valE, 64'h77);
      chk("ar_post_valid", 64'(M_valid), 64'd1);
      chk("ar_post_flags", 64'({cc_zf, cc_sf, cc_of}), 64'b100);

      // randomized run against the reference model, from a fresh reset
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mv = 1'b0; mic = 4'h1; mc = 1'b0; mve = 64'd0; mva = 64'd0; mde = 4'hF; mdm = 4'hF;
      mz = 1'b1; ms = 1'b0; mo = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic [63:0] ra, rb, rc;
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rb = ra;
         if ($urandom_range(0, 7) == 0) ra = 64'h8000_0000_0000_0000;
         @(negedge clk);
         drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ra, rb, rc,
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
         if ($urandom_range(0, 2) != 0) e_icode = 4'h6;
         #1;
         rx = ref_exe(e_icode, e_ifun, e_valA, e_valB, e_valC);
         xc = ref_cnd(e_ifun, mz, ms, mo);
         xf = (e_icode == 4'h2 && !xc) ? 4'hF : e_dstE;
         chk("rnd_e_cnd", 64'(e_cnd), 64'(xc));
         chk("rnd_e_valE", e_valE, rx[63:0]);
         chk("rnd_e_dstE_fwd", 64'(e_dstE_fwd), 64'(xf));
         if (!m_stall) begin
            if (e_valid && e_icode == 4'h6 && !m_exc) begin
               mz = (rx[63:0] == 64'd0); ms = rx[63]; mo = rx[64];
            end
            if (m_bubble || !e_valid) begin
               mv = 1'b0; mic = 4'h1; mc = 1'b0; mve = 64'd0; mva = 64'd0; mde = 4'hF; mdm = 4'hF;
            end else begin
               mv = 1'b1; mic = e_icode; mc = xc; mve = rx[63:0]; mva = e_valA; mde = xf; mdm = e_dstM;
            end
         end
         @(posedge clk); #1;
         chk("rnd_M_valid", 64'(M_valid), 64'(mv));
         chk("rnd_M_icode", 64'(M_icode), 64'(mic));
         chk("rnd_M_cnd", 64'(M_cnd), 64'(mc));
         chk("rnd_M_valE", M_valE, mve);
         chk("rnd_M_valA", M_valA, mva);
         chk("rnd_M_dstE", 64'(M_dstE), 64'(mde));
         chk("rnd_M_dstM", 64'(M_dstM), 64'(mdm));
         chk("rnd_flags", 64'({cc_zf, cc_sf, cc_of}), 64'({mz, ms, mo}));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
